// File: rtl/perf_counter_pkg.sv
// rtl/perf_counter_pkg.sv - shared state encoding and retire-count helpers for the performance-counter source
package perf_counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        DRAIN,
        DONE
    } perf_state_t;

    localparam int unsigned DEFAULT_RETIRE_WIDTH = 4;
    localparam int unsigned RETIRE_COUNT_WIDTH   = $clog2(DEFAULT_RETIRE_WIDTH + 1);

    // The retire-count port can encode more than the retire stage can actually deliver.
    function automatic int unsigned clamp_retire(input int unsigned count, input int unsigned limit);
        return (count > limit) ? limit : count;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - one wrapping accumulator with synchronous clear and enable
import perf_counter_pkg::*;

module perf_counter #(
    parameter int WIDTH     = 64,
    parameter int INC_WIDTH = RETIRE_COUNT_WIDTH
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 en,
    input  logic [INC_WIDTH-1:0] inc,
    output logic [WIDTH-1:0]     value
);

    always_ff @(posedge clock) begin
        if (clear) begin
            value <= '0;
        end else if (en) begin
            value <= value + WIDTH'(inc);
        end
    end

endmodule

// File: rtl/perf_counter_source.sv
// rtl/perf_counter_source.sv - per-core performance-counter producer with kernel-completion detection; stall counters built under PERF_STALL_COUNTERS_EN
import perf_counter_pkg::*;

module perf_counter_source #(
    parameter int NUM_WARPS     = 8,
    parameter int COUNTER_WIDTH = 64,
    parameter int RETIRE_WIDTH  = DEFAULT_RETIRE_WIDTH,
    parameter int FINISH_DELAY  = 16
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic [NUM_WARPS-1:0]                 warp_active,
    input  logic [$clog2(RETIRE_WIDTH+1)-1:0]    retire_count,
    input  logic [NUM_WARPS-1:0]                 warp_decoded,
    input  logic [NUM_WARPS-1:0]                 warp_eligible,
    input  logic [NUM_WARPS-1:0]                 warp_issued,
    input  logic [NUM_WARPS-1:0]                 warp_stall_waw,
    input  logic [NUM_WARPS-1:0]                 warp_stall_war,
    input  logic [NUM_WARPS-1:0]                 warp_stall_busy,
    output logic                                 finished,
    output logic [COUNTER_WIDTH-1:0]             inst_retired,
    output logic [COUNTER_WIDTH-1:0]             cycles,
    output logic [COUNTER_WIDTH-1:0]             cycles_decoded,
    output logic [COUNTER_WIDTH-1:0]             cycles_eligible,
    output logic [COUNTER_WIDTH-1:0]             cycles_issued,
    output logic [NUM_WARPS*COUNTER_WIDTH-1:0]   per_warp_cycles_decoded,
    output logic [NUM_WARPS*COUNTER_WIDTH-1:0]   per_warp_cycles_issued,
    output logic [NUM_WARPS*COUNTER_WIDTH-1:0]   per_warp_stalls_waw,
    output logic [NUM_WARPS*COUNTER_WIDTH-1:0]   per_warp_stalls_war,
    output logic [NUM_WARPS*COUNTER_WIDTH-1:0]   per_warp_stalls_busy
);

    localparam int RCW    = $clog2(RETIRE_WIDTH + 1);
    localparam int IDLE_W = $clog2(FINISH_DELAY + 1);

    perf_state_t        state, state_next;
    logic [IDLE_W-1:0]  idle_run, idle_run_next;
    logic               count_en;
    logic               flush;
    logic               any_active;
    logic [RCW-1:0]     retire_clamped;

    assign flush          = reset | clear;
    assign any_active     = |warp_active;
    assign retire_clamped = RCW'(clamp_retire(32'(retire_count), RETIRE_WIDTH));
    assign finished       = (state == DONE);

    always_ff @(posedge clock) begin
        if (flush) begin
            state    <= IDLE;
            idle_run <= '0;
        end else begin
            state    <= state_next;
            idle_run <= idle_run_next;
        end
    end

    // The IDLE->RUNNING cycle counts; the last DRAIN cycle before DONE counts too.
    always_comb begin
        state_next    = state;
        idle_run_next = idle_run;
        count_en      = 1'b0;
        case (state)
            IDLE: begin
                if (any_active) begin
                    state_next = RUNNING;
                    count_en   = 1'b1;
                end
            end
            RUNNING: begin
                count_en = 1'b1;
                if (!any_active) begin
                    idle_run_next = IDLE_W'(1);
                    state_next    = (FINISH_DELAY <= 1) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                count_en = 1'b1;
                if (any_active) begin
                    state_next    = RUNNING;
                    idle_run_next = '0;
                end else begin
                    idle_run_next = idle_run + IDLE_W'(1);
                    if (idle_run_next == IDLE_W'(FINISH_DELAY)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(RCW)) u_inst_retired (
        .clock(clock), .clear(flush), .en(count_en), .inc(retire_clamped), .value(inst_retired));
    perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_cycles (
        .clock(clock), .clear(flush), .en(count_en), .inc(1'b1), .value(cycles));
    perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_cycles_decoded (
        .clock(clock), .clear(flush), .en(count_en), .inc(|warp_decoded), .value(cycles_decoded));
    perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_cycles_eligible (
        .clock(clock), .clear(flush), .en(count_en), .inc(|warp_eligible), .value(cycles_eligible));
    perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_cycles_issued (
        .clock(clock), .clear(flush), .en(count_en), .inc(|warp_issued), .value(cycles_issued));

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
        perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_decoded (
            .clock(clock), .clear(flush), .en(count_en), .inc(warp_decoded[g]),
            .value(per_warp_cycles_decoded[g*COUNTER_WIDTH +: COUNTER_WIDTH]));
        perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_issued (
            .clock(clock), .clear(flush), .en(count_en), .inc(warp_issued[g]),
            .value(per_warp_cycles_issued[g*COUNTER_WIDTH +: COUNTER_WIDTH]));
`ifdef PERF_STALL_COUNTERS_EN
        perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_stall_waw (
            .clock(clock), .clear(flush), .en(count_en), .inc(warp_stall_waw[g]),
            .value(per_warp_stalls_waw[g*COUNTER_WIDTH +: COUNTER_WIDTH]));
        perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_stall_war (
            .clock(clock), .clear(flush), .en(count_en), .inc(warp_stall_war[g]),
            .value(per_warp_stalls_war[g*COUNTER_WIDTH +: COUNTER_WIDTH]));
        perf_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_stall_busy (
            .clock(clock), .clear(flush), .en(count_en), .inc(warp_stall_busy[g]),
            .value(per_warp_stalls_busy[g*COUNTER_WIDTH +: COUNTER_WIDTH]));
`endif
    end

`ifndef PERF_STALL_COUNTERS_EN
    logic unused_stall_inputs;
    assign unused_stall_inputs  = ^{warp_stall_waw, warp_stall_war, warp_stall_busy};
    assign per_warp_stalls_waw  = '0;
    assign per_warp_stalls_war  = '0;
    assign per_warp_stalls_busy = '0;
`endif

endmodule

// File: tb/tb_perf_counter_source.sv
// tb/tb_perf_counter_source.sv - randomized self-checking bench for perf_counter_source against a behavioural model
module tb_perf_counter_source;

    localparam int NW = 8;
    localparam int CW = 64;
    localparam int NCW = 4;
    localparam int RW = 4;
    localparam int FD = 16;

    logic clock = 1'b0;
    logic reset, clear;
    logic [NW-1:0] warp_active, warp_decoded, warp_eligible, warp_issued;
    logic [NW-1:0] warp_stall_waw, warp_stall_war, warp_stall_busy;
    logic [2:0] retire_count;

    logic w_finished;
    logic [CW-1:0] w_inst, w_cycles, w_cdec, w_celig, w_ciss;
    logic [NW*CW-1:0] w_pw_dec, w_pw_iss, w_waw, w_war, w_busy;

    logic n_finished;
    logic [NCW-1:0] n_inst, n_cycles, n_cdec, n_celig, n_ciss;
    logic [NW*NCW-1:0] n_pw_dec, n_pw_iss, n_waw, n_war, n_busy;

    int checks = 0;
    int failures = 0;

    longint unsigned m_inst, m_cycles, m_dec, m_elig, m_iss;
    longint unsigned m_pw_dec[NW], m_pw_iss[NW], m_waw[NW], m_war[NW], m_busy[NW];
    bit m_started, m_done;
    int m_idle;

    always #5 clock = ~clock;

    perf_counter_source #(.NUM_WARPS(NW), .COUNTER_WIDTH(CW), .RETIRE_WIDTH(RW), .FINISH_DELAY(FD)) dut (
        .clock(clock), .reset(reset), .clear(clear), .warp_active(warp_active),
        .retire_count(retire_count), .warp_decoded(warp_decoded), .warp_eligible(warp_eligible),
        .warp_issued(warp_issued), .warp_stall_waw(warp_stall_waw), .warp_stall_war(warp_stall_war),
        .warp_stall_busy(warp_stall_busy), .finished(w_finished), .inst_retired(w_inst),
        .cycles(w_cycles), .cycles_decoded(w_cdec), .cycles_eligible(w_celig), .cycles_issued(w_ciss),
        .per_warp_cycles_decoded(w_pw_dec), .per_warp_cycles_issued(w_pw_iss),
        .per_warp_stalls_waw(w_waw), .per_warp_stalls_war(w_war), .per_warp_stalls_busy(w_busy));

    perf_counter_source #(.NUM_WARPS(NW), .COUNTER_WIDTH(NCW), .RETIRE_WIDTH(RW), .FINISH_DELAY(FD)) dut_narrow (
        .clock(clock), .reset(reset), .clear(clear), .warp_active(warp_active),
        .retire_count(retire_count), .warp_decoded(warp_decoded), .warp_eligible(warp_eligible),
        .warp_issued(warp_issued), .warp_stall_waw(warp_stall_waw), .warp_stall_war(warp_stall_war),
        .warp_stall_busy(warp_stall_busy), .finished(n_finished), .inst_retired(n_inst),
        .cycles(n_cycles), .cycles_decoded(n_cdec), .cycles_eligible(n_celig), .cycles_issued(n_ciss),
        .per_warp_cycles_decoded(n_pw_dec), .per_warp_cycles_issued(n_pw_iss),
        .per_warp_stalls_waw(n_waw), .per_warp_stalls_war(n_war), .per_warp_stalls_busy(n_busy));

    // Model: counting starts at first activity and stops after FD consecutive idle cycles.
    function automatic void model_step();
        if (reset || clear) begin
            m_inst = 0; m_cycles = 0; m_dec = 0; m_elig = 0; m_iss = 0;
            for (int i = 0; i < NW; i++) begin
                m_pw_dec[i] = 0; m_pw_iss[i] = 0; m_waw[i] = 0; m_war[i] = 0; m_busy[i] = 0;
            end
            m_started = 0; m_done = 0; m_idle = 0;
        end else if (!m_done && (m_started || warp_active != 0)) begin
            m_started = 1;
            m_cycles += 1;
            m_inst += (retire_count > RW) ? RW : retire_count;
            if (warp_decoded != 0) m_dec += 1;
            if (warp_eligible != 0) m_elig += 1;
            if (warp_issued != 0) m_iss += 1;
            for (int i = 0; i < NW; i++) begin
                m_pw_dec[i] += warp_decoded[i];
                m_pw_iss[i] += warp_issued[i];
`ifdef PERF_STALL_COUNTERS_EN
                m_waw[i] += warp_stall_waw[i];
                m_war[i] += warp_stall_war[i];
                m_busy[i] += warp_stall_busy[i];
`endif
            end
            if (warp_active != 0) m_idle = 0;
            else m_idle += 1;
            if (m_idle == FD) m_done = 1;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        warp_active = '0; warp_decoded = '0; warp_eligible = '0; warp_issued = '0;
        warp_stall_waw = '0; warp_stall_war = '0; warp_stall_busy = '0; retire_count = '0;
    endtask

    task automatic drive_random(input logic [NW-1:0] active);
        warp_active = active;
        warp_decoded = NW'($urandom); warp_eligible = NW'($urandom); warp_issued = NW'($urandom);
        warp_stall_waw = NW'($urandom); warp_stall_war = NW'($urandom); warp_stall_busy = NW'($urandom);
        retire_count = 3'($urandom_range(0, 7));
    endtask

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; drive_idle();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 50; c++) begin
            drive_random('0);
            tick();
        end
        checks++;
        if ({w_inst, w_cycles, w_cdec, w_celig, w_ciss} !== '0 || w_pw_dec !== '0 || w_pw_iss !== '0) begin
            failures++; $display("FAIL reset_counters: got cycles=%0d inst=%0d, expected all 0", w_cycles, w_inst);
        end
        checks++;
        if ((w_waw | w_war | w_busy) !== '0) begin
            failures++; $display("FAIL reset_stalls: got nonzero stall counters, expected 0");
        end
        checks++;
        if (w_finished !== 1'b0) begin
            failures++; $display("FAIL reset_finished: got %0b expected 0", w_finished);
        end
    endtask

    task automatic test_single_warp();
        logic [CW-1:0] iss0;
        do_reset();
        warp_active = 8'h01; warp_issued = 8'h01;
        for (int c = 0; c < 10; c++) tick();
        drive_idle();
        for (int c = 0; c < FD - 1; c++) tick();
        checks++;
        if (w_finished !== 1'b0) begin
            failures++; $display("FAIL finish_early: got %0b after %0d idle cycles expected 0", w_finished, FD - 1);
        end
        tick();
        checks++;
        if (w_finished !== 1'b1) begin
            failures++; $display("FAIL finish_assert: got %0b expected 1", w_finished);
        end
        iss0 = w_pw_iss[0 +: CW];
        checks++;
        if (w_cycles !== 64'd26 || w_ciss !== 64'd10 || iss0 !== 64'd10) begin
            failures++; $display("FAIL single_warp_counts: got cycles=%0d issued=%0d warp0=%0d expected 26/10/10", w_cycles, w_ciss, iss0);
        end
        for (int c = 0; c < 10; c++) begin
            drive_random(NW'($urandom_range(1, 255)));
            tick();
        end
        iss0 = w_pw_iss[0 +: CW];
        checks++;
        if (w_cycles !== 64'd26 || w_ciss !== 64'd10 || iss0 !== 64'd10 || w_finished !== 1'b1) begin
            failures++; $display("FAIL frozen_after_done: got cycles=%0d issued=%0d warp0=%0d fin=%0b expected 26/10/10/1", w_cycles, w_ciss, iss0, w_finished);
        end
        drive_idle();
    endtask

    task automatic test_idle_gap();
        do_reset();
        for (int c = 0; c < 5; c++) begin drive_random(NW'($urandom_range(1, 255))); tick(); end
        drive_idle();
        for (int c = 0; c < FD - 1; c++) tick();
        for (int c = 0; c < 3; c++) begin drive_random(NW'($urandom_range(1, 255))); tick(); end
        checks++;
        if (w_finished !== 1'b0) begin
            failures++; $display("FAIL gap_no_finish: got %0b expected 0", w_finished);
        end
        drive_idle();
        for (int c = 0; c < FD; c++) tick();
        checks++;
        if (w_finished !== 1'b1 || w_cycles !== 64'd39) begin
            failures++; $display("FAIL gap_then_finish: got fin=%0b cycles=%0d expected 1/39", w_finished, w_cycles);
        end
    endtask

    task automatic test_retire_clamp();
        do_reset();
        warp_active = 8'h01;
        retire_count = 3'd4;
        for (int c = 0; c < 5; c++) tick();
        retire_count = 3'd7;
        tick();
        checks++;
        if (w_inst !== 64'd24) begin
            failures++; $display("FAIL retire_clamp: got %0d expected 24", w_inst);
        end
        drive_idle();
    endtask

    task automatic test_wrap();
        do_reset();
        warp_active = 8'h80; warp_issued = 8'h80; retire_count = 3'd3;
        for (int c = 0; c < 20; c++) tick();
        checks++;
        if (n_cycles !== 4'd4 || n_inst !== 4'd12 || n_ciss !== 4'd4) begin
            failures++; $display("FAIL wrap_narrow: got cycles=%0d inst=%0d issued=%0d expected 4/12/4", n_cycles, n_inst, n_ciss);
        end
        checks++;
        if (n_finished !== 1'b0 || w_cycles !== 64'd20 || w_inst !== 64'd60) begin
            failures++; $display("FAIL wrap_side_effect: got fin=%0b wide cycles=%0d inst=%0d expected 0/20/60", n_finished, w_cycles, w_inst);
        end
        drive_idle();
    endtask

    task automatic test_stall_clear();
        logic [CW-1:0] waw3, exp_waw3;
`ifdef PERF_STALL_COUNTERS_EN
        exp_waw3 = 64'd5;
`else
        exp_waw3 = 64'd0;
`endif
        do_reset();
        warp_active = 8'h08; warp_stall_waw = 8'h08;
        for (int c = 0; c < 5; c++) tick();
        waw3 = w_waw[3*CW +: CW];
        checks++;
        if (waw3 !== exp_waw3) begin
            failures++; $display("FAIL stall_waw3: got %0d expected %0d", waw3, exp_waw3);
        end
        drive_random(8'hff);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if ({w_inst, w_cycles, w_cdec, w_celig, w_ciss} !== '0 || (w_pw_dec | w_pw_iss | w_waw | w_war | w_busy) !== '0) begin
            failures++; $display("FAIL clear_mid_run: got cycles=%0d inst=%0d expected all 0", w_cycles, w_inst);
        end
        for (int c = 0; c < 3; c++) begin drive_random('0); tick(); end
        drive_random(8'h02);
        tick();
        checks++;
        if (w_cycles !== 64'd1 || w_finished !== 1'b0) begin
            failures++; $display("FAIL clear_to_idle: got cycles=%0d fin=%0b expected 1/0", w_cycles, w_finished);
        end
        drive_idle();
    endtask

    task automatic test_random();
        int len;
        longint unsigned e;
        do_reset();
        for (int b = 0; b < 20; b++) begin
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin drive_random(NW'($urandom_range(1, 255))); tick(); end
            len = $urandom_range(0, 18);
            for (int c = 0; c < len; c++) begin
                drive_random('0);
                tick();
                checks++;
                if (w_cycles !== m_cycles || w_inst !== m_inst || w_cdec !== m_dec || w_celig !== m_elig ||
                    w_ciss !== m_iss || w_finished !== m_done) begin
                    failures++;
                    $display("FAIL random_global: got cyc=%0d inst=%0d dec=%0d elig=%0d iss=%0d fin=%0b expected %0d/%0d/%0d/%0d/%0d/%0b",
                             w_cycles, w_inst, w_cdec, w_celig, w_ciss, w_finished, m_cycles, m_inst, m_dec, m_elig, m_iss, m_done);
                end
                checks++;
                e = m_cycles;
                if (n_cycles !== e[NCW-1:0] || n_finished !== m_done) begin
                    failures++; $display("FAIL random_narrow: got cyc=%0d fin=%0b expected %0d/%0b", n_cycles, n_finished, e[NCW-1:0], m_done);
                end
            end
        end
        for (int i = 0; i < NW; i++) begin
            checks++;
            if (w_pw_dec[i*CW +: CW] !== m_pw_dec[i] || w_pw_iss[i*CW +: CW] !== m_pw_iss[i] ||
                w_waw[i*CW +: CW] !== m_waw[i] || w_war[i*CW +: CW] !== m_war[i] || w_busy[i*CW +: CW] !== m_busy[i]) begin
                failures++;
                $display("FAIL random_per_warp[%0d]: got dec=%0d iss=%0d waw=%0d war=%0d busy=%0d expected %0d/%0d/%0d/%0d/%0d", i,
                         w_pw_dec[i*CW +: CW], w_pw_iss[i*CW +: CW], w_waw[i*CW +: CW], w_war[i*CW +: CW], w_busy[i*CW +: CW],
                         m_pw_dec[i], m_pw_iss[i], m_waw[i], m_war[i], m_busy[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0;
        drive_idle();
        test_reset();
        test_single_warp();
        test_idle_gap();
        test_retire_clamp();
        test_wrap();
        test_stall_clear();
        test_random();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
